// File: rtl/dct_pkg.sv
// Shared constants and the cosine phase fold for the 8-point DCT basis generator.
package dct_pkg;

    localparam int DCT_N    = 8;
    localparam int TBL_FRAC = 15;
    localparam int MAG_W    = TBL_FRAC + 2;
    localparam int PROD_W   = 2 * MAG_W;

    // round(cos(m*pi/16) * 2^15) for m = 8 down to 0 (index m selects entry m)
    localparam logic [8:0][MAG_W-1:0] COS_TBL = {
        17'd0,     17'd6393,  17'd12540, 17'd18205, 17'd23170,
        17'd27246, 17'd30274, 17'd32138, 17'd32768
    };

    typedef struct packed {
        logic       neg;
        logic [3:0] idx;
    } fold_t;

    // Map a phase in units of pi/16 (mod 32) onto the quarter-wave table.
    function automatic fold_t cos_fold(input logic [4:0] p);
        fold_t      f;
        logic [4:0] t;
        f.neg = 1'b0;
        t     = p;
        if (p <= 5'd8) begin
            f.neg = 1'b0;
            t     = p;
        end else if (p <= 5'd16) begin
            f.neg = 1'b1;
            t     = 5'd16 - p;
        end else if (p <= 5'd24) begin
            f.neg = 1'b1;
            t     = p - 5'd16;
        end else begin
            f.neg = 1'b0;
            t     = 5'd0 - p;
        end
        f.idx = t[3:0];
        return f;
    endfunction

endpackage

// File: rtl/dct_cos_1d.sv
// One-dimensional 8-point cosine term: (k, n) -> sign and 17-bit magnitude.
module dct_cos_1d
    import dct_pkg::*;
(
    input  logic [2:0]       k_i,
    input  logic [2:0]       n_i,
    output logic             neg_o,
    output logic [MAG_W-1:0] mag_o
);

    logic [4:0] phase;
    fold_t      fold;

    // Phase (2n+1)*k wraps naturally in 5 bits, giving the mod-32 reduction.
    always_comb begin
        phase = {1'b0, n_i, 1'b1} * {2'b00, k_i};
        fold  = cos_fold(phase);
        neg_o = fold.neg;
        mag_o = COS_TBL[fold.idx];
    end

endmodule

// File: rtl/dct_basis_gen.sv
// Streaming 2-D DCT basis generator: emits 64 terms c(k1,n1)*c(k2,n2) per frame.
module dct_basis_gen
    import dct_pkg::*;
#(
    parameter int FRAC  = 8,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       k1,
    input  logic [2:0]       k2,
    input  logic             col_major,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       n1_o,
    output logic [2:0]       n2_o,
    output logic [OUT_W-1:0] cos_term,
    output logic             last
);

    localparam int         SHIFT     = 2 * TBL_FRAC - FRAC;
    localparam logic [5:0] LAST_BEAT = 6'(DCT_N * DCT_N - 1);

    // Drop the fractional bits (truncating the magnitude) and apply the sign.
    function automatic logic signed [OUT_W-1:0] scale_term(input logic [PROD_W-1:0] prod,
                                                           input logic neg);
        logic signed [OUT_W-1:0] mag;
        mag = OUT_W'(prod >> SHIFT);
        return neg ? -mag : mag;
    endfunction

    logic       busy_q, busy_d;
    logic       iss_q, iss_d;
    logic [5:0] cnt_q, cnt_d;
    logic [2:0] k1_q, k2_q;
    logic       cm_q;
    logic       start_ok, adv;

    logic                    vld_p0, last_p0;
    logic [2:0]              n1_p0, n2_p0;
    logic                    neg1_p0, neg2_p0;
    logic [MAG_W-1:0]        mag1_p0, mag2_p0;

    logic                    vld_p1, last_p1, neg1_p1, neg2_p1;
    logic [2:0]              n1_p1, n2_p1;
    logic [MAG_W-1:0]        mag1_p1, mag2_p1;

    logic                    vld_p2, last_p2, neg_p2;
    logic [2:0]              n1_p2, n2_p2;
    logic [PROD_W-1:0]       prod_p2;

    logic                    vld_p3, last_p3;
    logic [2:0]              n1_p3, n2_p3;
    logic signed [OUT_W-1:0] term_p3;

    assign start_ok = start & ~busy_q;
    assign adv      = ~(vld_p3 & ~out_ready);

    // Frame control: accept start, step the beat counter, retire after the last beat.
    always_comb begin
        busy_d = busy_q;
        iss_d  = iss_q;
        cnt_d  = cnt_q;
        if (start_ok) begin
            busy_d = 1'b1;
            iss_d  = 1'b1;
            cnt_d  = '0;
        end else begin
            if (iss_q && adv) begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_BEAT) iss_d = 1'b0;
            end
            if (vld_p3 && out_ready && last_p3) busy_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            iss_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            iss_q  <= iss_d;
            cnt_q  <= cnt_d;
        end
    end

    // Frequencies and scan order are captured once per frame.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            k1_q <= k1;
            k2_q <= k2;
            cm_q <= col_major;
        end
    end

    // ---- S0: counter -> sample indices ----
    assign vld_p0  = iss_q;
    assign last_p0 = (cnt_q == LAST_BEAT);
    assign n1_p0   = cm_q ? cnt_q[2:0] : cnt_q[5:3];
    assign n2_p0   = cm_q ? cnt_q[5:3] : cnt_q[2:0];

    dct_cos_1d u_cos_row (
        .k_i   (k1_q),
        .n_i   (n1_p0),
        .neg_o (neg1_p0),
        .mag_o (mag1_p0)
    );

    dct_cos_1d u_cos_col (
        .k_i   (k2_q),
        .n_i   (n2_p0),
        .neg_o (neg2_p0),
        .mag_o (mag2_p0)
    );

    // Pipeline valids and the output stage; outputs only change on a valid beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
            last_p3 <= 1'b0;
            n1_p3   <= '0;
            n2_p3   <= '0;
            term_p3 <= '0;
        end else if (adv) begin
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
            // ---- S3: shift, sign, output register ----
            vld_p3  <= vld_p2;
            last_p3 <= vld_p2 & last_p2;
            if (vld_p2) begin
                n1_p3   <= n1_p2;
                n2_p3   <= n2_p2;
                term_p3 <= scale_term(prod_p2, neg_p2);
            end
        end
    end

    // Datapath registers for the fold and multiply stages.
    always_ff @(posedge clk) begin
        if (adv) begin
            // ---- S1: phase fold result ----
            neg1_p1 <= neg1_p0;
            neg2_p1 <= neg2_p0;
            mag1_p1 <= mag1_p0;
            mag2_p1 <= mag2_p0;
            n1_p1   <= n1_p0;
            n2_p1   <= n2_p0;
            last_p1 <= last_p0;
            // ---- S2: magnitude product ----
            prod_p2 <= PROD_W'(mag1_p1) * PROD_W'(mag2_p1);
            neg_p2  <= neg1_p1 ^ neg2_p1;
            n1_p2   <= n1_p1;
            n2_p2   <= n2_p1;
            last_p2 <= last_p1;
        end
    end

    assign busy      = busy_q;
    assign out_valid = vld_p3;
    assign n1_o      = n1_p3;
    assign n2_o      = n2_p3;
    assign cos_term  = term_p3;
    assign last      = last_p3;

endmodule

// File: doc/dct_basis_gen.md
# dct_basis_gen

Streaming 2-D DCT basis generator for the DCT datapath. It replaces the per-(k1,k2) cosine LUT modules with one parametrised block. On `start` it emits all 64 basis terms c(k1,n1)·c(k2,n2) for the requested frequency pair over a valid/ready stream, in fixed-point with FRAC fractional bits. The DCT accumulator consumes the stream directly.

## Interface
Parameters:
- `FRAC`, 8: fractional bits of `cos_term`. Legal range 0..15.
- `OUT_W`, 32: width of `cos_term`. Must be ≥ FRAC+2.

Ports:
- `clk`  in  1  single clock; every register is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request a frame. Sampled only when `busy`=0.
- `k1`  in  3  row frequency, latched at start.
- `k2`  in  3  column frequency, latched at start.
- `col_major`  in  1  scan order, latched at start. 0 = n2 fastest; 1 = n1 fastest.
- `busy`  out  1  a frame is in progress.
- `out_valid`  out  1  `cos_term`, `n1_o`, `n2_o` and `last` are valid.
- `out_ready`  in  1  downstream accepts the current beat.
- `n1_o`  out  3  sample row index of the current beat.
- `n2_o`  out  3  sample column index of the current beat.
- `cos_term`  out  OUT_W  signed two's-complement basis term.
- `last`  out  1  marks beat 63 of the frame.

## Operation
- Reset drives every output low: `busy`, `out_valid`, `last`, `n1_o`, `n2_o` and `cos_term` are all 0. Pipeline valids clear and counters return to 0.
- Frame start:
  - When `start`=1 and `busy`=0, the block latches k1, k2 and col_major and sets `busy` on the next edge.
  - `start` is ignored while `busy`=1.
- Index counter:
  - A 6-bit beat counter runs 0..63.
  - Row-major: n1 = cnt[5:3], n2 = cnt[2:0]. Column-major: the two fields are swapped.
- 1-D cosine, N=8:
  - Phase p = ((2n+1)·k) mod 32, in units of π/16.
  - Quarter-wave table T[0..8] = round(cos(mπ/16)·2^15), stored unsigned in 17 bits. T[0]=32768 and T[8]=0.
  - Fold on p:
    - p ≤ 8: +T[p]
    - 8 < p ≤ 16: −T[16−p]
    - 16 < p ≤ 24: −T[p−16]
    - p > 24: +T[32−p]
- Product:
  - Take the unsigned 34-bit magnitude product of the two table entries.
  - Shift it right by 30−FRAC; this truncates the magnitude toward zero.
  - Apply sign = s1 XOR s2, then sign-extend to OUT_W.
  - A zero magnitude outputs 0.
- Pipeline, four stages:
  - S0: counter.
  - S1: phase computation and fold.
  - S2: multiply.
  - S3: shift, sign and output register.
- Stall: when `out_valid`=1 and `out_ready`=0, every stage holds and the outputs stay bit-stable.
- End of frame:
  - A beat is accepted when `out_valid` and `out_ready` are both 1.
  - After the beat with `last`=1 is accepted, `busy` drops on the next edge.
  - The counter stops issuing after beat 63. There are no gaps while `out_ready` stays high.
- Reset mid-frame aborts the frame immediately. There is no partial flush.

## Timing
- Start to first data: with `start` accepted at edge 0, `busy`=1 after edge 1 and `out_valid`=1 after edge 4. Latency is 4 cycles.
- Throughput: one beat per cycle while `out_ready`=1. A full frame occupies 64 cycles plus the 4-cycle latency.
- Back-to-back frames: the earliest next `start` is the cycle after `busy` falls, so there is a 1-cycle gap.
- No combinational path exists from `out_ready` to any output other than the stall enable.

## Structure
- Package `dct_pkg` holds:
  - `localparam DCT_N = 8`
  - `localparam TBL_FRAC = 15`
  - the 9-entry quarter-wave table constant
  - a `cos_fold` function (phase → sign, index)
- One sub-module, `dct_cos_1d`: combinational k,n → {sign, 17-bit magnitude}. It is instantiated twice, once for (k1,n1) and once for (k2,n2).

## Test plan
- Reset, then idle: all outputs stay 0, and `start` with `out_ready`=0 produces no beat until `out_ready` rises.
- k1=4, k2=5, row-major, `out_ready`=1:
  - beats 0..7 = 100, −177, 35, 150, −150, −35, 177, −100
  - beat 8 = −100
  - beat 63 = −100 with `last`=1
  - first `out_valid` exactly 4 cycles after start
- k1=k2=0: all 64 beats = 256. With FRAC=12, all 64 beats = 4096. With FRAC=0, all 64 beats = 1.
- k1=4, k2=5 with `col_major`=1:
  - beat 1 has n1_o=1, n2_o=0 and value −100
  - beat 8 has n1_o=0, n2_o=1 and value −177
- Backpressure: hold `out_ready`=0 for 5 cycles at beat 10. Outputs stay stable, the total is exactly 64 beats, and the ordering is unchanged.
- Start while busy is ignored.
- `rst` pulsed at beat 30: all outputs are 0 on the following cycle. A new start for k1=1, k2=1 then gives beat 0 = round-trip value 246.
